video_text_writer: RTL and testbench
====================================

Name: video_text_writer

Overview:
- Write-side engine for the 64x32 character video RAM that the VGA display scanner reads.
- Accepts a stream of character codes over a valid/ready handshake.
- Stores each code as a 16-bit cell {attribute, glyph} at a hardware-tracked cursor.
- Handles CR/LF/BS/FF control codes, wraps at column 63, and scrolls by block-copying RAM rows upward.

Parameters:
- COLS, 64, characters per row; address column field is 6 bits.
- ROWS, 32, rows per screen; address row field is 5 bits.
- DEF_ATTR, 8'h0E, attribute byte used for the reset-time screen clear (white fg, black bg).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- CHAR_VALID  input  1  CHAR_DATA/ATTR valid.
- CHAR_DATA  input  8  character code.
- ATTR  input  8  attribute byte: bit0 inverse, bits3:1 fg BGR, bit4 blink, bits7:5 bg BGR.
- CHAR_READY  output  1  engine can accept a code this cycle.
- BUSY  output  1  scroll or clear in progress.
- RAM_ADDR  output  11  video RAM address {row[4:0], col[5:0]}.
- RAM_WDATA  output  16  {attribute, glyph}.
- RAM_WE  output  1  write strobe, one word per cycle.
- RAM_RDATA  input  16  RAM read data, valid one cycle after RAM_ADDR is presented.
- CURSOR_COL  output  6  current column.
- CURSOR_ROW  output  5  current row.

Behaviour:
- All outputs are registered.
- Reset values:
  - cursor 0/0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0.
  - CHAR_READY=0, BUSY=1.
  - state=CLEAR_ALL, latched fill attribute = DEF_ATTR.
- A transfer occurs on a rising edge with CHAR_VALID & CHAR_READY. CHAR_READY=1 only in IDLE. CHAR_DATA/ATTR are captured at the transfer edge.
- Printable code (any code not listed below):
  - Next cycle: RAM_WE=1, RAM_ADDR={row,col}, RAM_WDATA={ATTR,code}; state WRITE, CHAR_READY=0.
  - Then return to IDLE. Throughput is 1 code per 2 cycles.
  - After the write, col+1. If col was 63: col=0, then LF action.
- 0x0D CR: col=0; no RAM write; 1 cycle in WRITE with WE=0.
- 0x0A LF: if row<31, row+1. If row=31, row stays 31 and the engine enters SCROLL_RD. Column is unchanged.
- 0x08 BS: col-1 if col>0, else no change. No erase. Never moves to the previous row.
- 0x0C FF: latch ATTR as the fill attribute, cursor to 0/0, enter CLEAR_ALL.
- SCROLL_RD:
  - Drives RAM_ADDR=dst+64 with WE=0; dst starts at 0.
  - Next state SCROLL_WR.
- SCROLL_WR:
  - Drives RAM_ADDR=dst, RAM_WDATA=RAM_RDATA (the word read in the previous cycle), WE=1.
  - dst+1. If dst was 1983, go to CLEAR_LINE at address 1984; else go to SCROLL_RD.
- CLEAR_LINE:
  - Writes {fill attr of the triggering code's ATTR, 8'h20} to addresses 1984..2047, one per cycle, then IDLE.
  - Total scroll = 3968 + 64 cycles.
- CLEAR_ALL: writes {fill attr, 8'h20} to 0..2047, one per cycle, then IDLE.
- BUSY=1 in SCROLL_RD, SCROLL_WR, CLEAR_LINE and CLEAR_ALL, and 0 otherwise.
- Address arithmetic is 11-bit unsigned. The clear counter stops at 2047 and does not wrap to 0.
- RESET asserted mid-scroll or mid-clear:
  - Abort at the next edge, with no further writes from the aborted operation.
  - Restart CLEAR_ALL with DEF_ATTR.
- CHAR_VALID held while BUSY: no transfer, and the data is held by the source.

Optional Feature:
- Macro: VIDEO_TAB_EN.
- When defined:
  - 0x09 sets col=(col|7)+1 with no RAM write.
  - If the result exceeds 63: col=0, then LF action, including scroll at row 31.
- When undefined: 0x09 is treated as a printable glyph.

Test Plan:
- Reset release: 2048 WE pulses, all with RAM_WDATA=16'h0E20 at addresses 0..2047. CHAR_READY rises in the following cycle.
- Send 'A' (0x41) ATTR=0x1E at cursor 0/0: exactly one write, addr 0, data 16'h1E41. Cursor becomes col 1 row 0.
- Wrap: 64 printables on row 5. The last is written at addr 0x17F, then cursor=0/6, with no extra write.
- Scroll: preload row r with pattern {r,col}, set cursor to row 31, send 0x0A.
  - addr 0 receives row-1 data.
  - addr 1983 receives the old addr 2047 data.
  - 1984..2047 receive {ATTR,0x20}.
  - BUSY is high for 4032 cycles; cursor row stays 31.
- BS at col 0 leaves cursor unchanged. CR from col 40 sets col=0. Neither produces a WE.
- RESET asserted at scroll write #100: no WE on the next edge, then a full clear to 16'h0E20. With VIDEO_TAB_EN defined, 0x09 from col 60 gives col 0 and row+1.

Source files
------------

// File: rtl/video_text_writer.sv
// Write-side engine for the character video RAM scanned by the VGA display.
// Accepts character codes over valid/ready, stores {attribute, glyph} at a
// hardware cursor, interprets CR/LF/BS/FF, wraps at the last column and
// scrolls by block-copying RAM rows upward, then blanks the bottom line.
// Optional build macro: VIDEO_TAB_EN enables 0x09 as a tab-to-next-8 code;
// without it 0x09 is stored as an ordinary glyph.
module video_text_writer #(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROWS     = 32,
  parameter logic [7:0]  DEF_ATTR = 8'h0E
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  input  logic [7:0]  ATTR,
  output logic        CHAR_READY,
  output logic        BUSY,
  output logic [10:0] RAM_ADDR,
  output logic [15:0] RAM_WDATA,
  output logic        RAM_WE,
  input  logic [15:0] RAM_RDATA,
  output logic [5:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW
);

  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned AddrW = ColW + RowW;

  localparam logic [ColW-1:0]  LastCol    = ColW'(COLS - 1);
  localparam logic [RowW-1:0]  LastRow    = RowW'(ROWS - 1);
  localparam logic [AddrW-1:0] RowStep    = AddrW'(COLS);
  localparam logic [AddrW-1:0] LineBase   = AddrW'((ROWS - 1) * COLS);
  localparam logic [AddrW-1:0] ScrollLast = LineBase - AddrW'(1);
  localparam logic [AddrW-1:0] LastAddr   = AddrW'(ROWS * COLS - 1);

  localparam logic [7:0] ChBs    = 8'h08;
  localparam logic [7:0] ChLf    = 8'h0A;
  localparam logic [7:0] ChFf    = 8'h0C;
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChSpace = 8'h20;
`ifdef VIDEO_TAB_EN
  localparam logic [7:0] ChTab   = 8'h09;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StScrollRd,
    StScrollWr,
    StClearLine,
    StClearAll
  } state_e;

  state_e           state;
  logic [7:0]       fill_attr;  // attribute for full-screen clears
  logic [7:0]       line_attr;  // attribute of the last accepted code
  logic             lf_pend;    // line feed owed once the WRITE cycle ends
  logic [AddrW-1:0] dst_addr;   // scroll copy destination
  logic [AddrW-1:0] clr_addr;   // clear fill address
  logic             clr_done;   // clear counter reached its last address

`ifdef VIDEO_TAB_EN
  logic [ColW:0] tab_col;
  // One extra bit so a tab past the last column is visible as overflow.
  assign tab_col = {1'b0, CURSOR_COL | ColW'(7)} + (ColW + 1)'(1);
`endif

  // Single FSM: each edge registers the RAM strobe/address/data and the
  // handshake outputs for the cycle that follows.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= StClearAll;
      fill_attr  <= DEF_ATTR;
      line_attr  <= DEF_ATTR;
      lf_pend    <= 1'b0;
      dst_addr   <= '0;
      clr_addr   <= '0;
      clr_done   <= 1'b0;
      CURSOR_COL <= '0;
      CURSOR_ROW <= '0;
      RAM_WE     <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
      CHAR_READY <= 1'b0;
      BUSY       <= 1'b1;
    end else begin
      RAM_WE <= 1'b0;
      unique case (state)
        StIdle: begin
          if (CHAR_VALID && CHAR_READY) begin
            CHAR_READY <= 1'b0;
            line_attr  <= ATTR;
            state      <= StWrite;
            case (CHAR_DATA)
              ChCr: CURSOR_COL <= '0;
              ChLf: lf_pend <= 1'b1;
              ChBs: begin
                if (CURSOR_COL != '0) CURSOR_COL <= CURSOR_COL - ColW'(1);
              end
              ChFf: begin
                fill_attr  <= ATTR;
                CURSOR_COL <= '0;
                CURSOR_ROW <= '0;
                clr_addr   <= '0;
                clr_done   <= 1'b0;
                BUSY       <= 1'b1;
                state      <= StClearAll;
              end
`ifdef VIDEO_TAB_EN
              ChTab: begin
                if (tab_col > {1'b0, LastCol}) begin
                  CURSOR_COL <= '0;
                  lf_pend    <= 1'b1;
                end else begin
                  CURSOR_COL <= tab_col[ColW-1:0];
                end
              end
`endif
              default: begin
                RAM_WE    <= 1'b1;
                RAM_ADDR  <= {CURSOR_ROW, CURSOR_COL};
                RAM_WDATA <= {ATTR, CHAR_DATA};
                if (CURSOR_COL == LastCol) begin
                  CURSOR_COL <= '0;
                  lf_pend    <= 1'b1;
                end else begin
                  CURSOR_COL <= CURSOR_COL + ColW'(1);
                end
              end
            endcase
          end
        end

        StWrite: begin
          lf_pend <= 1'b0;
          if (lf_pend && (CURSOR_ROW == LastRow)) begin
            // Bottom row: start the scroll with the first read already issued.
            RAM_ADDR <= RowStep;
            dst_addr <= '0;
            BUSY     <= 1'b1;
            state    <= StScrollWr;
          end else begin
            if (lf_pend) CURSOR_ROW <= CURSOR_ROW + RowW'(1);
            CHAR_READY <= 1'b1;
            state      <= StIdle;
          end
        end

        StScrollRd: begin
          RAM_ADDR <= dst_addr + RowStep;
          state    <= StScrollWr;
        end

        StScrollWr: begin
          // RAM_RDATA holds the word addressed during the read cycle.
          RAM_WE    <= 1'b1;
          RAM_ADDR  <= dst_addr;
          RAM_WDATA <= RAM_RDATA;
          dst_addr  <= dst_addr + AddrW'(1);
          if (dst_addr == ScrollLast) begin
            clr_addr <= LineBase;
            clr_done <= 1'b0;
            state    <= StClearLine;
          end else begin
            state <= StScrollRd;
          end
        end

        StClearLine, StClearAll: begin
          if (clr_done) begin
            BUSY       <= 1'b0;
            CHAR_READY <= 1'b1;
            state      <= StIdle;
          end else begin
            RAM_WE    <= 1'b1;
            RAM_ADDR  <= clr_addr;
            RAM_WDATA <= {((state == StClearAll) ? fill_attr : line_attr), ChSpace};
            // Saturate at the top address rather than wrapping to 0.
            if (clr_addr == LastAddr) clr_done <= 1'b1;
            else clr_addr <= clr_addr + AddrW'(1);
          end
        end

        default: begin
          state    <= StClearAll;
          clr_addr <= '0;
          clr_done <= 1'b0;
          BUSY     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_text_writer.sv
// Directed bench for video_text_writer with a behavioural video RAM model.
module tb_video_text_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CHAR_VALID;
  logic [7:0]  CHAR_DATA;
  logic [7:0]  ATTR;
  logic        CHAR_READY;
  logic        BUSY;
  logic [10:0] RAM_ADDR;
  logic [15:0] RAM_WDATA;
  logic        RAM_WE;
  logic [15:0] RAM_RDATA;
  logic [5:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;

  always #5 CLK = ~CLK;

  video_text_writer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CHAR_VALID (CHAR_VALID),
    .CHAR_DATA  (CHAR_DATA),
    .ATTR       (ATTR),
    .CHAR_READY (CHAR_READY),
    .BUSY       (BUSY),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_WE     (RAM_WE),
    .RAM_RDATA  (RAM_RDATA),
    .CURSOR_COL (CURSOR_COL),
    .CURSOR_ROW (CURSOR_ROW)
  );

  // Video RAM model: read data for the presented address is available by
  // the next rising edge; preload fills every word with a known pattern.
  logic [15:0] mem [0:2047];
  logic        preload = 1'b0;
  int          we_cnt  = 0;
  logic [10:0] last_addr = '0;
  logic [15:0] last_data = '0;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [15:0] pat(input int i);
    return 16'(i) ^ 16'hA500;
  endfunction

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else if (RAM_WE) begin
      mem[RAM_ADDR] <= RAM_WDATA;
    end
    if (RAM_WE) begin
      we_cnt    <= we_cnt + 1;
      last_addr <= RAM_ADDR;
      last_data <= RAM_WDATA;
    end
  end

  assign RAM_RDATA = mem[RAM_ADDR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (CHAR_READY !== 1'b1 && n < 6000) begin
      @(negedge CLK);
      n++;
    end
    if (CHAR_READY !== 1'b1) check({tag, "_timeout"}, 32'(CHAR_READY), 1);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    wait_ready("send");
    CHAR_VALID = 1'b1;
    CHAR_DATA  = c;
    ATTR       = a;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
  endtask

  // Follows a full-screen clear: counts writes, checks address order and
  // data, and measures cycles from the last write to CHAR_READY.
  task automatic clear_watch(output int nwe, output int bad, output int gap);
    int last = -1;
    int cyc;
    nwe = 0;
    bad = 0;
    for (cyc = 0; cyc < 5000; cyc++) begin
      @(negedge CLK);
      if (CHAR_READY === 1'b1) break;
      if (RAM_WE === 1'b1) begin
        if (RAM_ADDR !== nwe[10:0] || RAM_WDATA !== 16'h0E20) bad++;
        nwe++;
        last = cyc;
      end
    end
    gap = cyc - last;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, nwe, bad, gap, bc, n;

    RESET      = 1'b1;
    CHAR_VALID = 1'b0;
    CHAR_DATA  = '0;
    ATTR       = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_we", 32'(RAM_WE), 0);
    check("rst_busy", 32'(BUSY), 1);
    check("rst_ready", 32'(CHAR_READY), 0);
    check("rst_addr", 32'(RAM_ADDR), 0);
    check("rst_wdata", 32'(RAM_WDATA), 0);
    check("rst_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 0);

    // Power-on clear
    RESET = 1'b0;
    clear_watch(nwe, bad, gap);
    check("clr_we_count", nwe, 2048);
    check("clr_addr_data", bad, 0);
    check("clr_ready_gap", gap, 1);
    check("clr_ready", 32'(CHAR_READY), 1);
    check("clr_busy", 32'(BUSY), 0);

    // 'A' at 0/0
    w0 = we_cnt;
    send(8'h41, 8'h1E);
    wait_ready("a");
    check("a_we_count", we_cnt - w0, 1);
    check("a_addr", 32'(last_addr), 0);
    check("a_data", 32'(last_data), 32'h1E41);
    check("a_col", 32'(CURSOR_COL), 1);
    check("a_row", 32'(CURSOR_ROW), 0);

    // Move to row 5, column 0
    send(8'h0D, 8'h0E);
    for (int i = 0; i < 5; i++) send(8'h0A, 8'h0E);
    wait_ready("lf5");
    check("pos_row5", 32'({CURSOR_ROW, CURSOR_COL}), 32'({5'd5, 6'd0}));

    // Wrap: 64 printables on row 5
    w0 = we_cnt;
    for (int i = 0; i < 64; i++) send(8'(8'h21 + i), 8'h0E);
    wait_ready("wrap");
    check("wrap_we_count", we_cnt - w0, 64);
    check("wrap_last_addr", 32'(last_addr), 32'h17F);
    check("wrap_last_data", 32'(last_data), 32'h0E60);
    check("wrap_first_word", 32'(mem[11'h140]), 32'h0E21);
    check("wrap_col", 32'(CURSOR_COL), 0);
    check("wrap_row", 32'(CURSOR_ROW), 6);

    // BS at column 0
    w0 = we_cnt;
    send(8'h08, 8'h0E);
    wait_ready("bs0");
    check("bs0_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 32'({5'd6, 6'd0}));
    check("bs0_no_we", we_cnt - w0, 0);

    // 40 printables, BS to 39, CR to 0
    for (int i = 0; i < 40; i++) send(8'(8'h41 + (i % 26)), 8'h0E);
    wait_ready("p40");
    check("p40_col", 32'(CURSOR_COL), 40);
    w0 = we_cnt;
    send(8'h08, 8'h0E);
    wait_ready("bs40");
    check("bs40_col", 32'(CURSOR_COL), 39);
    send(8'h0D, 8'h0E);
    wait_ready("cr");
    check("cr_col", 32'(CURSOR_COL), 0);
    check("cr_row", 32'(CURSOR_ROW), 6);
    check("bs_cr_no_we", we_cnt - w0, 0);

    // Down to row 31 without scrolling
    w0 = we_cnt;
    for (int i = 0; i < 25; i++) send(8'h0A, 8'h0E);
    wait_ready("lf25");
    check("row31", 32'(CURSOR_ROW), 31);
    check("lf_no_we", we_cnt - w0, 0);

    // Scroll with a patterned screen
    preload = 1'b1;
    @(negedge CLK);
    preload = 1'b0;
    w0 = we_cnt;
    send(8'h0A, 8'h3C);
    bc = 0;
    n  = 0;
    while (CHAR_READY !== 1'b1 && n < 10000) begin
      if (BUSY === 1'b1) bc++;
      @(negedge CLK);
      n++;
    end
    check("scroll_done", 32'(CHAR_READY), 1);
    check("scroll_busy_cycles", bc, 4032);
    check("scroll_we_count", we_cnt - w0, 2048);
    check("scroll_row", 32'(CURSOR_ROW), 31);
    check("scroll_col", 32'(CURSOR_COL), 0);
    check("scroll_addr0", 32'(mem[0]), 32'(pat(64)));
    check("scroll_addr1983", 32'(mem[1983]), 32'(pat(2047)));
    check("scroll_addr1984", 32'(mem[1984]), 32'h3C20);
    bad = 0;
    for (int i = 0; i < 1984; i++) if (mem[i] !== pat(i + 64)) bad++;
    for (int i = 1984; i < 2048; i++) if (mem[i] !== 16'h3C20) bad++;
    check("scroll_image", bad, 0);

    // Reset at scroll write #100
    send(8'h0A, 8'h0E);
    n = 0;
    for (int k = 0; k < 10000 && n < 100; k++) begin
      @(negedge CLK);
      if (RAM_WE === 1'b1) n++;
    end
    check("abort_wr100_seen", n, 100);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_no_we", 32'(RAM_WE), 0);
    check("abort_busy", 32'(BUSY), 1);
    check("abort_ready", 32'(CHAR_READY), 0);
    check("abort_cursor", 32'({CURSOR_ROW, CURSOR_COL}), 0);
    RESET = 1'b0;
    clear_watch(nwe, bad, gap);
    check("reclr_we_count", nwe, 2048);
    check("reclr_addr_data", bad, 0);
    check("reclr_ready", 32'(CHAR_READY), 1);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== 16'h0E20) bad++;
    check("reclr_image", bad, 0);

    // Tab from column 60
    for (int i = 0; i < 60; i++) send(8'(8'h41 + (i % 26)), 8'h0E);
    wait_ready("p60");
    check("p60_col", 32'(CURSOR_COL), 60);
    w0 = we_cnt;
    send(8'h09, 8'h0E);
    wait_ready("tab");
`ifdef VIDEO_TAB_EN
    check("tab_col", 32'(CURSOR_COL), 0);
    check("tab_row", 32'(CURSOR_ROW), 1);
    check("tab_no_we", we_cnt - w0, 0);
`else
    check("tab_glyph_we", we_cnt - w0, 1);
    check("tab_glyph_addr", 32'(last_addr), 60);
    check("tab_glyph_data", 32'(last_data), 32'h0E09);
    check("tab_glyph_col", 32'(CURSOR_COL), 61);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
